// File: rtl/gpu_host_ctrl.sv
// rtl/gpu_host_ctrl.sv - host command sequencer owning the GPU datapath host ports
// Optional run-time watchdog is compiled in with GPU_HOST_CTRL_WATCHDOG_EN.
module gpu_host_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        gpu_rst_n,
  output logic        imem_host_we,
  output logic [6:0]  imem_host_addr,
  output logic [31:0] imem_host_data,
  output logic        dmem_host_we,
  output logic [7:0]  dmem_host_wr_addr,
  output logic [63:0] dmem_host_wr_data,
  output logic [7:0]  dmem_host_rd_addr,
  input  logic [63:0] dmem_host_rd_data,
  input  logic        halted,
  input  logic [31:0] pc_in,
  output logic [1:0]  state_out,
  output logic        timeout
);

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2} rd_phase_t;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_WR_IMEM   = 3'd1;
  localparam logic [2:0] OP_WR_DMEM   = 3'd2;
  localparam logic [2:0] OP_RD_DMEM   = 3'd3;
  localparam logic [2:0] OP_START     = 3'd4;
  localparam logic [2:0] OP_STOP      = 3'd5;
  localparam logic [2:0] OP_RD_STATUS = 3'd6;

`ifdef GPU_HOST_CTRL_WATCHDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

  state_t      state_q, state_d;
  rd_phase_t   rd_phase_q, rd_phase_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        timeout_q, timeout_d;
  logic        cmd_ready_d, rsp_valid_d, rsp_err_d, gpu_rst_n_d;
  logic [63:0] rsp_data_d;
  logic        imem_we_d, dmem_we_d;
  logic [6:0]  imem_addr_d;
  logic [31:0] imem_data_d;
  logic [7:0]  dmem_wr_addr_d, dmem_rd_addr_d;
  logic [63:0] dmem_wr_data_d;

  assign state_out = state_q;
  assign timeout   = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_LOAD;
      rd_phase_q        <= RD_IDLE;
      cycle_cnt_q       <= '0;
      timeout_q         <= 1'b0;
      cmd_ready         <= 1'b1;
      rsp_valid         <= 1'b0;
      rsp_err           <= 1'b0;
      rsp_data          <= '0;
      gpu_rst_n         <= 1'b0;
      imem_host_we      <= 1'b0;
      imem_host_addr    <= '0;
      imem_host_data    <= '0;
      dmem_host_we      <= 1'b0;
      dmem_host_wr_addr <= '0;
      dmem_host_wr_data <= '0;
      dmem_host_rd_addr <= '0;
    end else begin
      state_q           <= state_d;
      rd_phase_q        <= rd_phase_d;
      cycle_cnt_q       <= cycle_cnt_d;
      timeout_q         <= timeout_d;
      cmd_ready         <= cmd_ready_d;
      rsp_valid         <= rsp_valid_d;
      rsp_err           <= rsp_err_d;
      rsp_data          <= rsp_data_d;
      gpu_rst_n         <= gpu_rst_n_d;
      imem_host_we      <= imem_we_d;
      imem_host_addr    <= imem_addr_d;
      imem_host_data    <= imem_data_d;
      dmem_host_we      <= dmem_we_d;
      dmem_host_wr_addr <= dmem_wr_addr_d;
      dmem_host_wr_data <= dmem_wr_data_d;
      dmem_host_rd_addr <= dmem_rd_addr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rd_phase_d     = rd_phase_q;
    cycle_cnt_d    = cycle_cnt_q;
    timeout_d      = timeout_q;
    cmd_ready_d    = cmd_ready;
    rsp_valid_d    = 1'b0;
    rsp_err_d      = 1'b0;
    rsp_data_d     = '0;
    gpu_rst_n_d    = gpu_rst_n;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_host_addr;
    imem_data_d    = imem_host_data;
    dmem_we_d      = 1'b0;
    dmem_wr_addr_d = dmem_host_wr_addr;
    dmem_wr_data_d = dmem_host_wr_data;
    dmem_rd_addr_d = dmem_host_rd_addr;

    // Run-time events first; an accepted STOP below overrides them.
    if (state_q == S_RUN) begin
      if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (halted) begin
        state_d = S_DONE;
      end
`ifdef GPU_HOST_CTRL_WATCHDOG_EN
      else if (cycle_cnt_q == WDOG_LAST) begin
        state_d     = S_LOAD;
        gpu_rst_n_d = 1'b0;
        timeout_d   = 1'b1;
      end
`endif
    end

    // Read pipeline: address out after E0, RAM data valid after E1, captured at E2.
    case (rd_phase_q)
      RD_ADDR: rd_phase_d = RD_DATA;
      RD_DATA: begin
        rd_phase_d  = RD_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = dmem_host_rd_data;
        cmd_ready_d = 1'b1;
      end
      default: rd_phase_d = RD_IDLE;
    endcase

    if (cmd_valid && cmd_ready) begin
      rsp_valid_d = 1'b1;
      case (cmd_op)
        OP_NOP: ;
        OP_WR_IMEM: begin
          if (state_q == S_LOAD) begin
            imem_we_d   = 1'b1;
            imem_addr_d = cmd_addr[6:0];
            imem_data_d = cmd_wdata[31:0];
          end else begin
            rsp_err_d = 1'b1;
          end
        end
        OP_WR_DMEM: begin
          if (state_q == S_LOAD) begin
            dmem_we_d      = 1'b1;
            dmem_wr_addr_d = cmd_addr;
            dmem_wr_data_d = cmd_wdata;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
        OP_RD_DMEM: begin
          if (state_q == S_RUN) begin
            rsp_err_d = 1'b1;
          end else begin
            rsp_valid_d    = 1'b0;
            dmem_rd_addr_d = cmd_addr;
            rd_phase_d     = RD_ADDR;
            cmd_ready_d    = 1'b0;
          end
        end
        OP_START: begin
          if (state_q == S_LOAD) begin
            state_d     = S_RUN;
            gpu_rst_n_d = 1'b1;
            cycle_cnt_d = '0;
            timeout_d   = 1'b0;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
        OP_STOP: begin
          state_d     = S_LOAD;
          gpu_rst_n_d = 1'b0;
          cycle_cnt_d = cycle_cnt_q;
          timeout_d   = timeout_q;
        end
        OP_RD_STATUS: rsp_data_d = {cycle_cnt_q, pc_in};
        default: rsp_err_d = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_host_ctrl.sv
// tb/tb_gpu_host_ctrl.sv - scoreboard bench for gpu_host_ctrl
module tb_gpu_host_ctrl;

  localparam logic [2:0] OP_NOP = 3'd0, OP_WR_IMEM = 3'd1, OP_WR_DMEM = 3'd2, OP_RD_DMEM = 3'd3;
  localparam logic [2:0] OP_START = 3'd4, OP_STOP = 3'd5, OP_RD_STATUS = 3'd6, OP_RSVD = 3'd7;
  localparam logic [31:0] PC = 32'hCAFE_0ABC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_addr = 8'd0;
  logic [63:0] cmd_wdata = 64'd0;
  logic        rsp_valid, rsp_err, gpu_rst_n;
  logic [63:0] rsp_data;
  logic        imem_host_we, dmem_host_we;
  logic [6:0]  imem_host_addr;
  logic [31:0] imem_host_data;
  logic [7:0]  dmem_host_wr_addr, dmem_host_rd_addr;
  logic [63:0] dmem_host_wr_data;
  logic [63:0] dmem_host_rd_data;
  logic        halted = 1'b0;
  logic [31:0] pc_in = PC;
  logic [1:0]  state_out;
  logic        timeout;

  gpu_host_ctrl #(
`ifdef GPU_HOST_CTRL_WATCHDOG_EN
    .TIMEOUT_CYCLES(16)
`else
    .TIMEOUT_CYCLES(65536)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .gpu_rst_n(gpu_rst_n),
    .imem_host_we(imem_host_we), .imem_host_addr(imem_host_addr), .imem_host_data(imem_host_data),
    .dmem_host_we(dmem_host_we), .dmem_host_wr_addr(dmem_host_wr_addr),
    .dmem_host_wr_data(dmem_host_wr_data), .dmem_host_rd_addr(dmem_host_rd_addr),
    .dmem_host_rd_data(dmem_host_rd_data),
    .halted(halted), .pc_in(pc_in), .state_out(state_out), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath data memory stand-in with one-cycle read latency.
  logic [63:0] tb_dmem [256];
  always @(posedge clk) begin
    if (dmem_host_we) tb_dmem[dmem_host_wr_addr] <= dmem_host_wr_data;
    dmem_host_rd_data <= tb_dmem[dmem_host_rd_addr];
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic        err;
    logic [63:0] data;
    logic        chk;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        if (e.chk) check("rsp_data", rsp_data, e.data);
        check("rsp_lat", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Drives one command; must be called between edges. lat = extra edges after acceptance.
  task automatic send(input logic [2:0] op, input logic [7:0] addr, input logic [63:0] wd,
                      input logic e_err, input logic e_chk, input logic [63:0] e_data, input int lat);
    exp_t e;
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    e.err  = e_err;
    e.data = e_data;
    e.chk  = e_chk;
    e.due  = cyc + 1 + lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench did not complete");
  end

  initial begin : main
    int t;
    repeat (3) @(negedge clk);
    check("rst_state", 64'(state_out), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_flags", 64'({gpu_rst_n, rsp_valid, rsp_err, imem_host_we, dmem_host_we, timeout}), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_addrs", 64'({imem_host_addr, dmem_host_wr_addr, dmem_host_rd_addr}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load phase
    send(OP_WR_IMEM, 8'h05, 64'hDEADBEEF, 1'b0, 1'b0, 64'd0, 0);
    @(negedge clk);
    check("imem_we", 64'(imem_host_we), 64'd1);
    check("imem_addr", 64'(imem_host_addr), 64'h05);
    check("imem_data", 64'(imem_host_data), 64'hDEADBEEF);
    send(OP_WR_DMEM, 8'h10, 64'h0123456789ABCDEF, 1'b0, 1'b0, 64'd0, 0);
    @(negedge clk);
    check("imem_we_pulse", 64'(imem_host_we), 64'd0);
    check("dmem_we", 64'(dmem_host_we), 64'd1);
    check("dmem_addr", 64'(dmem_host_wr_addr), 64'h10);
    check("dmem_data", dmem_host_wr_data, 64'h0123456789ABCDEF);
    send(OP_RD_DMEM, 8'h10, 64'd0, 1'b0, 1'b1, 64'h0123456789ABCDEF, 2);
    check("dmem_we_pulse", 64'(dmem_host_we), 64'd0);
    @(negedge clk);
    check("rd_busy0", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("rd_busy1", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("rd_ready", 64'(cmd_ready), 64'd1);
    send(OP_NOP, 8'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0);

    // Run, illegal ops in RUN, halt after 20 RUN cycles
    send(OP_START, 8'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0);
    t = cyc;
    @(negedge clk);
    check("run_state", 64'(state_out), 64'd1);
    check("run_gpu_rst_n", 64'(gpu_rst_n), 64'd1);
    send(OP_WR_DMEM, 8'h20, 64'h55, 1'b1, 1'b0, 64'd0, 0);
    @(negedge clk);
    check("run_no_we", 64'(dmem_host_we), 64'd0);
    send(OP_RD_DMEM, 8'h10, 64'd0, 1'b1, 1'b1, 64'd0, 0);
    while (cyc < t + 19) @(negedge clk);
    halted = 1'b1;
    @(negedge clk);
    check("done_state", 64'(state_out), 64'd2);
    check("done_gpu_rst_n", 64'(gpu_rst_n), 64'd1);
    send(OP_RD_STATUS, 8'd0, 64'd0, 1'b0, 1'b1, {32'd20, PC}, 0);
    send(OP_START, 8'd0, 64'd0, 1'b1, 1'b0, 64'd0, 0);
    send(OP_RSVD, 8'd0, 64'd0, 1'b1, 1'b0, 64'd0, 0);
    send(OP_STOP, 8'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0);
    halted = 1'b0;

    // STOP and halted at the same edge
    send(OP_START, 8'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0);
    t = cyc;
    while (cyc < t + 5) @(negedge clk);
    halted = 1'b1;
    send(OP_STOP, 8'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0);
    @(negedge clk);
    check("stop_wins_state", 64'(state_out), 64'd0);
    check("stop_gpu_rst_n", 64'(gpu_rst_n), 64'd0);
    halted = 1'b0;
    send(OP_RD_STATUS, 8'd0, 64'd0, 1'b0, 1'b1, {32'd5, PC}, 0);

`ifdef GPU_HOST_CTRL_WATCHDOG_EN
    send(OP_START, 8'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0);
    t = cyc;
    while (cyc < t + 15) @(negedge clk);
    check("wd_still_run", 64'(state_out), 64'd1);
    @(negedge clk);
    check("wd_state", 64'(state_out), 64'd0);
    check("wd_gpu_rst_n", 64'(gpu_rst_n), 64'd0);
    check("wd_timeout", 64'(timeout), 64'd1);
    @(negedge clk);
    check("wd_sticky", 64'(timeout), 64'd1);
    send(OP_START, 8'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0);
    @(negedge clk);
    check("wd_cleared", 64'(timeout), 64'd0);
    send(OP_STOP, 8'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0);
`else
    send(OP_START, 8'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0);
    t = cyc;
    while (cyc < t + 100) @(negedge clk);
    check("long_run_state", 64'(state_out), 64'd1);
    check("long_run_timeout", 64'(timeout), 64'd0);
    send(OP_RD_STATUS, 8'd0, 64'd0, 1'b0, 1'b1, {32'd100, PC}, 0);
    send(OP_STOP, 8'd0, 64'd0, 1'b0, 1'b0, 64'd0, 0);
`endif

    // Async reset one cycle after a read is accepted
    send(OP_RD_DMEM, 8'h10, 64'd0, 1'b0, 1'b1, 64'h0123456789ABCDEF, 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_state", 64'(state_out), 64'd0);
    check("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("arst_flags", 64'({gpu_rst_n, rsp_valid, rsp_err, imem_host_we, dmem_host_we, timeout}), 64'd0);
    check("arst_addrs", 64'({imem_host_addr, dmem_host_wr_addr, dmem_host_rd_addr}), 64'd0);
    check("arst_data", 64'(imem_host_data) | dmem_host_wr_data | rsp_data, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_state", 64'(state_out), 64'd0);
    repeat (5) @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpu_host_ctrl.md
Name: gpu_host_ctrl

Overview:
- Host-side sequencer that sits directly upstream of the GPU datapath and owns all of its host-facing ports.
- Accepts simple commands over a valid/ready bus: write instruction memory, write data memory, read data memory, start, stop, read status.
- Generates the datapath reset (holds the GPU in reset while loading), detects HALT, and counts run cycles.
- Optionally enforces a run-time watchdog.

Parameters:
- TIMEOUT_CYCLES, 65536: watchdog limit in RUN cycles. Used only when the watchdog is compiled in.

Ports:
- clk  in  1  clock (single domain)
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  0 NOP, 1 WR_IMEM, 2 WR_DMEM, 3 RD_DMEM, 4 START, 5 STOP, 6 RD_STATUS, 7 reserved
- cmd_addr  in  8  memory address; WR_IMEM uses [6:0]
- cmd_wdata  in  64  write data; WR_IMEM uses [31:0]
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  64  read data or status word
- rsp_err  out  1  command illegal in current state; qualified by rsp_valid
- gpu_rst_n  out  1  drives the datapath rst_n
- imem_host_we / imem_host_addr / imem_host_data  out  1/7/32  datapath instruction-memory write port
- dmem_host_we / dmem_host_wr_addr / dmem_host_wr_data  out  1/8/64  datapath data-memory write port
- dmem_host_rd_addr  out  8  datapath data-memory read address
- dmem_host_rd_data  in  64  datapath read data; 1-cycle latency
- halted  in  1  datapath HALT status
- pc_in  in  32  datapath pc_out
- state_out  out  2  0 LOAD, 1 RUN, 2 DONE
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values:
  - state LOAD; gpu_rst_n=0; cmd_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_data=0; all write enables 0.
  - All address and data outputs 0; cycle_cnt=0; timeout=0.
- Handshake:
  - A command is accepted at the edge where cmd_valid && cmd_ready (edge E0).
  - Every accepted command, including NOP and reserved, produces exactly one rsp_valid pulse. Reserved op gives rsp_err=1.
- Write commands (WR_IMEM, WR_DMEM):
  - Legal only in LOAD.
  - Address, data and the matching we are registered at E0. we is high for exactly one cycle.
  - rsp_valid is high in that same cycle. cmd_ready stays 1, so back-to-back writes sustain one per cycle.
  - In RUN or DONE: no we, rsp_err=1.
- RD_DMEM:
  - Legal in LOAD and DONE.
  - dmem_host_rd_addr is registered at E0; RAM data is valid after E1.
  - rsp_data is captured at E2, with rsp_valid high in the following cycle.
  - cmd_ready=0 from E0 until E2.
  - In RUN: rsp_err=1, rsp_data=0, 1-cycle response.
- RD_STATUS:
  - Legal in all states.
  - rsp_data = {cycle_cnt[31:0], pc_in[31:0]}, sampled at E0, with rsp_valid in the next cycle.
- START:
  - LOAD→RUN at E0.
  - gpu_rst_n=1 from E0; cycle_cnt cleared to 0; timeout cleared.
  - In RUN or DONE: rsp_err=1.
- STOP:
  - Any state→LOAD; gpu_rst_n=0 from E0.
  - cycle_cnt is held (not cleared).
  - Datapath memories keep their contents.
- RUN:
  - cycle_cnt increments every cycle, saturating at 0xFFFFFFFF.
  - halted is sampled only in RUN. Seeing halted=1 at an edge moves to DONE.
  - cycle_cnt freezes at the value reached at that edge.
  - gpu_rst_n stays 1 in DONE.
- Simultaneous events:
  - STOP accepted at the same edge halted=1 is seen: STOP wins, next state LOAD.
  - A watchdog expiry at the same edge as halted=1: halted wins, timeout stays 0.
- Async reset mid-operation:
  - Any pending read or response is dropped with no rsp_valid.
  - All outputs return to their reset values immediately.
- Outputs are registered; no combinational path from cmd_* to outputs except cmd_ready, which is a registered state decode.

Optional Feature:
- Macro: GPU_HOST_CTRL_WATCHDOG_EN.
- Defined:
  - In RUN, when cycle_cnt == TIMEOUT_CYCLES-1 and halted=0, the next state is LOAD.
  - gpu_rst_n goes to 0 (freezing GPU stores) and timeout=1.
  - timeout is sticky until the next accepted START or rst_n.
- Undefined:
  - No watchdog; RUN persists until halted or STOP.
  - timeout is tied to 0 and TIMEOUT_CYCLES is ignored.

Test Plan:
- Load: in LOAD, WR_IMEM addr 0x05 data 0xDEADBEEF, then WR_DMEM addr 0x10 data 0x0123456789ABCDEF.
  - Each produces a 1-cycle we pulse with the correct addr/data, rsp_valid the same cycle, rsp_err=0.
  - RD_DMEM 0x10 then returns 0x0123456789ABCDEF with rsp_valid 3 cycles after acceptance and cmd_ready low for 2 cycles.
- Run/halt: START, then drive halted=1 after 20 RUN cycles.
  - state_out goes 0→1→2 and gpu_rst_n=1.
  - RD_STATUS returns cycle_cnt=20 and pc_in in [31:0].
- Illegal ops:
  - In RUN: WR_DMEM gives rsp_err=1 with no dmem_host_we; RD_DMEM gives rsp_err=1.
  - START in DONE gives rsp_err=1.
  - cmd_op=7 gives rsp_err=1.
- STOP vs halt: assert STOP and halted=1 at the same edge.
  - Next state is LOAD, gpu_rst_n=0.
  - cycle_cnt is preserved through STOP.
- Watchdog (macro defined, TIMEOUT_CYCLES=16): START with halted held 0.
  - After 16 RUN cycles: state LOAD, gpu_rst_n=0, timeout=1.
  - The next START clears timeout.
  - With the macro undefined, the bench stays in RUN for 100 cycles.
- Async reset: assert rst_n low one cycle after RD_DMEM acceptance.
  - No rsp_valid is produced; all outputs are at reset values.
  - After release, cmd_ready=1 in LOAD.
